// File: rtl/util_timestamp_pkg.sv
// Shared timestamp-framing definitions for the insert and unpack sides.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, timestamp field width, every-clamp helper and
// the timestamp-beat pack function that fixes the field position within a beat.
package util_timestamp_pkg;

   localparam int TS_WIDTH      = 64;
   // Widest beat the pack function can produce; callers cast down to their DW.
   localparam int TS_BEAT_MAX_W = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TS   = 2'd1,
      ST_DATA = 2'd2,
      ST_PASS = 2'd3
   } ts_state_t;

   function automatic logic [31:0] clamp_every(input logic [31:0] every,
                                               input logic [31:0] every_max);
      return (every > every_max) ? every_max : every;
   endfunction

   // Timestamp occupies bits [TS_WIDTH-1:0]; everything above is zero.
   function automatic logic [TS_BEAT_MAX_W-1:0] ts_beat_pack(input logic [TS_WIDTH-1:0] ts);
      logic [TS_BEAT_MAX_W-1:0] beat;
      beat               = '0;
      beat[TS_WIDTH-1:0] = ts;
      return beat;
   endfunction

endpackage

// File: rtl/util_axis_reg_slice.sv
// One-deep valid/ready output register.
// Latency: 1 cycle from input accept to output valid.
// Backpressure: accepts when empty or drained in the same cycle; data holds while stalled.
//
// Ports: i_clk/i_resetn (sync, active-low), i_in_vld/o_in_rdy/i_in_dat upstream,
//        o_out_vld/i_out_rdy/o_out_dat downstream.
module util_axis_reg_slice #(
   parameter int DW = 64
) (
   input  logic          i_clk,
   input  logic          i_resetn,
   input  logic          i_in_vld,
   output logic          o_in_rdy,
   input  logic [DW-1:0] i_in_dat,
   output logic          o_out_vld,
   input  logic          i_out_rdy,
   output logic [DW-1:0] o_out_dat
);

   logic          r_vld;
   logic [DW-1:0] r_dat;

   assign o_in_rdy  = !r_vld || i_out_rdy;
   assign o_out_vld = r_vld;
   assign o_out_dat = r_dat;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_vld <= 1'b0;
         r_dat <= '0;
      end else if (o_in_rdy) begin
         r_vld <= i_in_vld;
         if (i_in_vld) r_dat <= i_in_dat;
      end
   end

endmodule

// File: rtl/util_axis_timestamp_insert.sv
// Inserts a timestamp beat ahead of every block of timestamp_every data beats.
// Latency: 1 cycle input accept to output valid; every_q+1 output cycles per block.
// Backpressure: s_axis_ready follows output-register space; TS beats wait for space too.
//
// Ports: i_dma_clk, i_resetn (sync, active-low); i_start_timestamp / i_timestamp_every
//        latched on the rising edge of i_s_axis_xfer_req; i_s_axis_* input beats;
//        o_m_axis_* framed output; o_block_count = saturating count of TS beats emitted.
module util_axis_timestamp_insert
   import util_timestamp_pkg::*;
#(
   parameter  int NUM_OF_CHANNELS     = 4,
   parameter  int SAMPLE_DATA_WIDTH   = 16,
   parameter  int SAMPLES_PER_CHANNEL = 1,
   parameter  int TIMESTAMP_EVERY_MAX = 65536,
   localparam int DW = NUM_OF_CHANNELS * SAMPLE_DATA_WIDTH * SAMPLES_PER_CHANNEL
) (
   input  logic          i_dma_clk,
   input  logic          i_resetn,
   input  logic [63:0]   i_start_timestamp,
   input  logic [31:0]   i_timestamp_every,
   output logic [31:0]   o_block_count,
   input  logic          i_s_axis_valid,
   output logic          o_s_axis_ready,
   input  logic [DW-1:0] i_s_axis_data,
   input  logic          i_s_axis_xfer_req,
   output logic          o_m_axis_valid,
   input  logic          i_m_axis_ready,
   output logic [DW-1:0] o_m_axis_data,
   output logic          o_m_axis_xfer_req
);

   if (DW < TS_WIDTH || DW > TS_BEAT_MAX_W) begin : g_bad_dw
      $error("util_axis_timestamp_insert: DW must be in [64, 1024]");
   end

   ts_state_t     r_state;
   logic          r_xfer_d;
   logic [63:0]   r_ts;
   logic [31:0]   r_every;
   logic [31:0]   r_beat_cnt;
   logic [31:0]   r_block_count;

   logic          w_xfer_rise;
   logic          w_xfer_fall;
   logic          w_slot_free;
   logic          w_s_rdy;
   logic          w_accept;
   logic          w_ts_load;
   logic          w_slice_vld;
   logic [DW-1:0] w_slice_dat;
   logic [DW-1:0] w_ts_beat;
   logic [31:0]   w_every_new;

   assign w_xfer_rise = i_s_axis_xfer_req && !r_xfer_d;
   assign w_xfer_fall = !i_s_axis_xfer_req && r_xfer_d;
   assign w_every_new = clamp_every(i_timestamp_every, 32'(TIMESTAMP_EVERY_MAX));

   assign w_s_rdy  = (r_state == ST_DATA || r_state == ST_PASS) && i_s_axis_xfer_req && w_slot_free;
   assign w_accept = i_s_axis_valid && w_s_rdy;
   // A TS beat is only loaded while the transfer is still active, so a falling
   // edge in TS drops the not-yet-loaded timestamp.
   assign w_ts_load = (r_state == ST_TS) && i_s_axis_xfer_req && w_slot_free;

   assign w_ts_beat   = DW'(ts_beat_pack(r_ts));
   assign w_slice_vld = w_ts_load || w_accept;
   assign w_slice_dat = w_ts_load ? w_ts_beat : i_s_axis_data;

   util_axis_reg_slice #(.DW(DW)) u_out_reg (
      .i_clk     (i_dma_clk),
      .i_resetn  (i_resetn),
      .i_in_vld  (w_slice_vld),
      .o_in_rdy  (w_slot_free),
      .i_in_dat  (w_slice_dat),
      .o_out_vld (o_m_axis_valid),
      .i_out_rdy (i_m_axis_ready),
      .o_out_dat (o_m_axis_data)
   );

   always_ff @(posedge i_dma_clk) begin
      if (!i_resetn) begin
         r_state       <= ST_IDLE;
         r_xfer_d      <= 1'b0;
         r_ts          <= '0;
         r_every       <= '0;
         r_beat_cnt    <= '0;
         r_block_count <= '0;
      end else begin
         r_xfer_d <= i_s_axis_xfer_req;
         if (w_xfer_rise) begin
            r_ts       <= i_start_timestamp;
            r_every    <= w_every_new;
            r_beat_cnt <= '0;
            r_state    <= (w_every_new != 32'd0) ? ST_TS : ST_PASS;
         end else if (w_xfer_fall) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_TS: begin
                  if (w_ts_load) begin
                     r_ts    <= r_ts + (64'(r_every) * 64'(SAMPLES_PER_CHANNEL));
                     r_state <= ST_DATA;
                     if (r_block_count != 32'hFFFF_FFFF)
                        r_block_count <= r_block_count + 32'd1;
                  end
               end
               ST_DATA: begin
                  if (w_accept) begin
                     if (r_beat_cnt + 32'd1 == r_every) begin
                        r_beat_cnt <= '0;
                        r_state    <= ST_TS;
                     end else begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_s_axis_ready    = w_s_rdy;
   assign o_block_count     = r_block_count;
   // Stays high until the last pending beat has left the output register.
   assign o_m_axis_xfer_req = r_xfer_d || o_m_axis_valid;

endmodule

// File: tb/tb_util_axis_timestamp_insert.sv
// Self-checking bench for util_axis_timestamp_insert.
// Latency: n/a (testbench).
// Backpressure: drives m_axis_ready constant, toggling or random.
module tb_util_axis_timestamp_insert;

   localparam int          DW      = 64;
   localparam int          SPC     = 1;
   localparam int unsigned EVERY_MAX = 65536;

   logic          clk = 1'b0;
   logic          resetn;
   logic [63:0]   start_ts;
   logic [31:0]   every;
   logic [31:0]   block_count;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_xfer;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_xfer;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;
   logic [63:0] tot_blocks;
   logic        prev_xfer;

   always #5 clk = ~clk;

   util_axis_timestamp_insert dut (
      .i_dma_clk         (clk),
      .i_resetn          (resetn),
      .i_start_timestamp (start_ts),
      .i_timestamp_every (every),
      .o_block_count     (block_count),
      .i_s_axis_valid    (s_valid),
      .o_s_axis_ready    (s_ready),
      .i_s_axis_data     (s_data),
      .i_s_axis_xfer_req (s_xfer),
      .o_m_axis_valid    (m_valid),
      .i_m_axis_ready    (m_ready),
      .o_m_axis_data     (m_data),
      .o_m_axis_xfer_req (m_xfer)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         s_valid = 1'b0;
         s_xfer  = 1'b0;
         m_ready = 1'b1;
      end
      prev_xfer = 1'b0;
   endtask

   // ready_mode: 0 = always ready, 1 = toggle every cycle, 2 = random.
   task automatic run_xfer(input logic [63:0] start, input logic [31:0] every_in,
                           input int n, input bit counting_data,
                           input int ready_mode, input bit gaps);
      logic [DW-1:0] beats[$];
      logic [DW-1:0] exp_q[$];
      logic [63:0]   eff;
      logic [DW-1:0] held;
      logic          stalled;
      int            idx;
      int            cyc;
      int            budget;

      eff = (every_in > EVERY_MAX) ? 64'(EVERY_MAX) : 64'(every_in);
      for (int i = 0; i < n; i++) begin
         if (counting_data)
            beats.push_back({16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)});
         else
            beats.push_back({$urandom, $urandom});
      end
      // Reference framing: block b starts with TS = start + b*every*SPC.
      for (int i = 0; i < n; i++) begin
         if (eff != 0 && (64'(i) % eff) == 0)
            exp_q.push_back(start + (64'(i) / eff) * eff * 64'(SPC));
         exp_q.push_back(beats[i]);
      end
      if (eff != 0) tot_blocks = tot_blocks + (64'(n) + eff - 1) / eff;

      idx     = 0;
      cyc     = 0;
      stalled = 1'b0;
      held    = '0;
      budget  = 8 * n + 200;
      forever begin
         @(negedge clk);
         if (cyc == 0) begin
            start_ts = start;
            every    = every_in;
            s_xfer   = 1'b1;
         end else begin
            // Mid-transfer changes must be ignored.
            start_ts = {$urandom, $urandom};
            every    = $urandom_range(0, 9);
         end
         if (idx == n) s_xfer = 1'b0;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = cyc[0];
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         s_valid = (idx < n) && (!gaps || $urandom_range(0, 3) != 0);
         s_data  = s_valid ? beats[idx] : '0;
         #4;
         check("m_xfer_req", 64'(m_xfer), 64'(prev_xfer | m_valid));
         if (stalled) begin
            check("stall_vld", 64'(m_valid), 64'd1);
            check("stall_dat", m_data, held);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("extra_beat_vld", 64'(m_valid), 64'd0);
            else check("beat", m_data, exp_q.pop_front());
         end
         stalled = m_valid && !m_ready;
         held    = m_data;
         if (s_valid && s_ready) idx++;
         prev_xfer = s_xfer;
         cyc++;
         if (idx == n && !s_xfer && exp_q.size() == 0 && !m_valid) break;
         if (cyc > budget) begin
            check("drain_timeout", 64'(exp_q.size()) + 64'(n - idx), 64'd0);
            break;
         end
      end
      check("block_count", 64'(block_count), tot_blocks);
      check("s_ready_idle", 64'(s_ready), 64'd0);
      idle(2);
   endtask

   initial begin
      resetn     = 1'b0;
      start_ts   = '0;
      every      = '0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_xfer     = 1'b0;
      m_ready    = 1'b1;
      tot_blocks = '0;
      prev_xfer  = 1'b0;

      repeat (3) @(negedge clk);
      #4;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", m_data, 64'd0);
      check("rst_block_count", 64'(block_count), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_m_xfer", 64'(m_xfer), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      idle(2);

      // Passthrough, framing, backpressure.
      run_xfer(64'd0,   32'd0, 12, 1'b1, 0, 1'b0);
      run_xfer(64'd100, 32'd4, 48, 1'b0, 0, 1'b0);
      run_xfer(64'd100, 32'd4, 48, 1'b0, 1, 1'b0);
      run_xfer(64'd100, 32'd4, 48, 1'b0, 2, 1'b1);
      // Partial block, then a fresh transfer.
      run_xfer(64'd37,  32'd4, 6,  1'b0, 0, 1'b0);
      run_xfer(64'd500, 32'd4, 3,  1'b0, 2, 1'b1);
      // Wrap of the 64-bit timestamp.
      run_xfer(64'hFFFF_FFFF_FFFF_FFFE, 32'd4, 8, 1'b0, 0, 1'b0);
      // Random block sizes.
      for (int t = 0; t < 3; t++)
         run_xfer({$urandom, $urandom}, 32'($urandom_range(1, 7)),
                  $urandom_range(5, 30), 1'b0, 2, 1'b1);
      // Clamp: blocks of 65536 beats.
      run_xfer(64'd1000, 32'h0010_0000, 65536 + 3, 1'b0, 0, 1'b0);

      // Reset in the middle of a block.
      @(negedge clk);
      start_ts = 64'd7;
      every    = 32'd4;
      s_xfer   = 1'b1;
      m_ready  = 1'b1;
      repeat (4) begin
         s_valid = 1'b1;
         s_data  = {$urandom, $urandom};
         @(negedge clk);
      end
      resetn  = 1'b0;
      s_xfer  = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #4;
      check("mid_rst_m_valid", 64'(m_valid), 64'd0);
      check("mid_rst_block_count", 64'(block_count), 64'd0);
      check("mid_rst_s_ready", 64'(s_ready), 64'd0);
      check("mid_rst_m_xfer", 64'(m_xfer), 64'd0);
      tot_blocks = '0;
      idle(2);
      run_xfer(64'd9, 32'd3, 7, 1'b0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
